// File: rtl/ldst_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ldst_pkg                                                         |
// | Load/store control encodings and responder FSM state type.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package ldst_pkg;

  localparam logic [2:0] C_LB  = 3'b000;
  localparam logic [2:0] C_LH  = 3'b001;
  localparam logic [2:0] C_LW  = 3'b010;
  localparam logic [2:0] C_LBU = 3'b011;
  localparam logic [2:0] C_LHU = 3'b100;
  localparam logic [2:0] C_SB  = 3'b101;
  localparam logic [2:0] C_SH  = 3'b110;
  localparam logic [2:0] C_SW  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  function automatic logic is_store(input logic [2:0] ctrl);
    return (ctrl == C_SB) || (ctrl == C_SH) || (ctrl == C_SW);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ldst_lane_format.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ldst_lane_format                                                 |
// | Store lane alignment, load extraction and alignment fault check. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module ldst_lane_format
  import ldst_pkg::*;
(
  input  logic [2:0]  i_ctrl,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_we,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_we         = 4'b0000;
    o_wdata      = i_wdata;
    o_rdata      = 32'd0;
    o_misaligned = 1'b0;
    case (i_ctrl)
      C_LB:  o_rdata = {{24{w_byte[7]}}, w_byte};
      C_LBU: o_rdata = {24'd0, w_byte};
      C_LH: begin
        o_rdata      = {{16{w_half[15]}}, w_half};
        o_misaligned = i_addr_lo[0];
      end
      C_LHU: begin
        o_rdata      = {16'd0, w_half};
        o_misaligned = i_addr_lo[0];
      end
      C_LW: begin
        o_rdata      = i_rdata;
        o_misaligned = |i_addr_lo;
      end
      C_SB: begin
        o_we    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      C_SH: begin
        o_we         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata      = {2{i_wdata[15:0]}};
        o_misaligned = i_addr_lo[0];
      end
      default: begin
        o_we         = 4'b1111;
        o_wdata      = i_wdata;
        o_misaligned = |i_addr_lo;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_access_responder                                             |
// | Single-outstanding load/store engine against a sync-read memory. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mem_access_responder
  import ldst_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_ctrl,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_misaligned,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t            r_state;
  logic [2:0]        r_ctrl;
  logic [1:0]        r_addr_lo;
  logic [ADDR_W-3:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_mem_en;
  logic [3:0]        r_mem_we;
  logic              r_resp_valid;
  logic [31:0]       r_resp_rdata;
  logic              r_resp_mis;

  logic [2:0]        w_fmt_ctrl;
  logic [1:0]        w_fmt_addr_lo;
  logic [3:0]        w_we;
  logic [31:0]       w_wdata_al;
  logic [31:0]       w_rdata_fmt;
  logic              w_mis;

  // The formatter sees the live request while idle and the captured one afterwards.
  assign w_fmt_ctrl    = (r_state == ST_IDLE) ? req_ctrl      : r_ctrl;
  assign w_fmt_addr_lo = (r_state == ST_IDLE) ? req_addr[1:0] : r_addr_lo;

  ldst_lane_format u_fmt (
    .i_ctrl       (w_fmt_ctrl),
    .i_addr_lo    (w_fmt_addr_lo),
    .i_wdata      (req_wdata),
    .i_rdata      (mem_rdata),
    .o_we         (w_we),
    .o_wdata      (w_wdata_al),
    .o_rdata      (w_rdata_fmt),
    .o_misaligned (w_mis)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ctrl       <= 3'd0;
      r_addr_lo    <= 2'd0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 32'd0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 4'b0000;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_mis   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_ctrl       <= req_ctrl;
            r_addr_lo    <= req_addr[1:0];
            r_mem_addr   <= req_addr[ADDR_W-1:2];
            r_mem_wdata  <= w_wdata_al;
            r_resp_rdata <= 32'd0;
            r_resp_mis   <= w_mis;
            if (w_mis) begin
              r_resp_valid <= 1'b1;
              r_state      <= ST_RESP;
            end else begin
              r_mem_en <= 1'b1;
              r_mem_we <= w_we;
              r_state  <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 4'b0000;
          if (is_store(r_ctrl)) begin
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_resp_rdata <= w_rdata_fmt;
          r_resp_valid <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_mem_en     <= 1'b0;
          r_mem_we     <= 4'b0000;
          r_resp_valid <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready       = (r_state == ST_IDLE) && !rst;
  assign resp_valid      = r_resp_valid;
  assign resp_rdata      = r_resp_rdata;
  assign resp_misaligned = r_resp_mis;
  assign mem_en          = r_mem_en;
  assign mem_we          = r_mem_we;
  assign mem_addr        = r_mem_addr;
  assign mem_wdata       = r_mem_wdata;

endmodule
`default_nettype wire
